// File: rtl/card_layout_shuffler_pkg.sv
// Shared types and constants for the card layout shuffler slice.
package lab3_params;

  typedef enum logic [1:0] {SH_IDLE, SH_INIT, SH_SWAP, SH_DONE} shuffle_state_e;

  localparam logic [15:0] LFSR16_TAPS = 16'hB400;

  // Galois step for x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR16_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/card_layout_shuffler_if.sv
// Start/layout handshake between the shuffler and the game datapath.
interface card_layout_shuffler_if #(
  parameter int unsigned N_CARDS = 16
);
  logic       start_i;
  logic [3:0] layout_o [N_CARDS-1:0];
  logic       busy_o;
  logic       done_o;
  logic       valid_o;
  logic [3:0] rnd4_o;

  modport master (output start_i, input layout_o, busy_o, done_o, valid_o, rnd4_o);
  modport slave  (input start_i, output layout_o, busy_o, done_o, valid_o, rnd4_o);
endinterface

// File: rtl/card_layout_shuffler_lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is forced to 1 to avoid lock-up.
module lfsr16
  import lab3_params::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);
  localparam logic [15:0] SEED_EFF = (SEED == '0) ? 16'h0001 : SEED;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEED_EFF;
    else     state <= lfsr16_next(state);
  end
endmodule

// File: rtl/card_layout_shuffler.sv
// Fisher-Yates shuffle of N_CARDS/2 symbol pairs, one swap per cycle.
module card_layout_shuffler
  import lab3_params::*;
#(
  parameter int unsigned N_CARDS   = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  card_layout_shuffler_if.slave   bus
);
  localparam logic [3:0] IDX_TOP = 4'(N_CARDS - 1);

  shuffle_state_e state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        valid_q;
  logic [3:0]  layout_q [N_CARDS-1:0];
  logic [15:0] lfsr;
  logic [4:0]  span;
  logic [7:0]  prod;
  logic [3:0]  j;
  logic        unused_bits;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .state(lfsr));

  // j = floor(r * (idx+1) / 16) with r < 16, so j never exceeds idx.
  assign span        = {1'b0, idx_q} + 5'd1;
  assign prod        = {4'b0000, lfsr[3:0]} * {3'b000, span};
  assign j           = prod[7:4];
  assign unused_bits = ^{lfsr[15:4], prod[3:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SH_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      SH_IDLE: if (bus.start_i) state_d = SH_INIT;
      SH_INIT: begin
        idx_d   = IDX_TOP;
        state_d = SH_SWAP;
      end
      SH_SWAP: begin
        idx_d = idx_q - 4'd1;
        if (idx_q == 4'd1) state_d = SH_DONE;
      end
      SH_DONE: state_d = SH_IDLE;
      default: state_d = SH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      for (int unsigned k = 0; k < N_CARDS; k++) layout_q[k] <= 4'(k >> 1);
    end else begin
      case (state_q)
        SH_INIT: begin
          valid_q <= 1'b0;
          for (int unsigned k = 0; k < N_CARDS; k++) layout_q[k] <= 4'(k >> 1);
        end
        SH_SWAP: begin
          layout_q[idx_q] <= layout_q[j];
          layout_q[j]     <= layout_q[idx_q];
        end
        SH_DONE: valid_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.layout_o = layout_q;
  assign bus.busy_o   = (state_q != SH_IDLE);
  assign bus.done_o   = (state_q == SH_DONE);
  assign bus.valid_o  = valid_q;
  assign bus.rnd4_o   = lfsr[3:0];
endmodule

// File: doc/card_layout_shuffler.md
# card_layout_shuffler

Produces the randomized 16-card board layout consumed by the game datapath: eight symbol pairs placed by a hardware Fisher-Yates shuffle driven by an internal LFSR. It sits directly upstream of the game datapath, which captures `layout_o` while its own reset is held. The top level holds the datapath in reset until this block reports `valid_o`.

## Interface
- `N_CARDS`, default 16: number of cards. Must be even, 2..16. Symbols run 0..N_CARDS/2-1.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.
- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start_i`  in  1: request a new shuffle; sampled only in IDLE.
- `layout_o`  out  4×N_CARDS (unpacked `[N_CARDS-1:0]`): symbol id per card slot.
- `busy_o`  out  1: shuffle in progress (state ≠ IDLE).
- `done_o`  out  1: one-cycle pulse when the layout is final.
- `valid_o`  out  1: layout complete and stable since the last `done_o`.
- `rnd4_o`  out  4: `lfsr[3:0]`, exported as the datapath's `rnd4_i` for auto-picks.

## Operation
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Shift: `lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 0)`.
  - Advances every cycle in every state, so the timing of `start_i` adds entropy.
- FSM states and transitions:
  - IDLE → INIT when `start_i`=1.
  - INIT (1 cycle): `layout[k] <= k>>1` for all k. Sets `idx <= N_CARDS-1` and clears `valid_o`.
  - SWAP (N_CARDS-1 cycles):
    - Compute j = (lfsr[3:0] × (idx+1)) >> 4. Use an 8-bit product; j is always ≤ idx.
    - Exchange `layout[idx]` and `layout[j]`; no change if j = idx.
    - `idx <= idx-1`. Leave SWAP after processing idx = 1.
  - DONE (1 cycle): `done_o`=1, `valid_o <= 1`, then return to IDLE.
- `start_i` in INIT, SWAP or DONE is ignored; no queuing.
- `start_i` in IDLE with `valid_o`=1 is accepted. A reshuffle restarts from the ordered pairs, and `valid_o` drops in INIT.
- `layout_o` is a direct register view. It may change every SWAP cycle, so consumers must qualify it with `valid_o`.
- Invariant after DONE: every symbol 0..N_CARDS/2-1 appears exactly twice.

## Timing
- Reset values:
  - `layout_o[k]` = k>>1 (ordered pairs).
  - `busy_o`=0, `done_o`=0, `valid_o`=0.
  - `lfsr` = `LFSR_SEED` (or 1 if the seed is 0), so `rnd4_o` = `LFSR_SEED[3:0]` (or 1).
  - State IDLE.
- If `start_i` is high at edge t:
  - `busy_o`=1 from t+1 through the DONE cycle.
  - INIT occupies cycle t+1.
  - SWAP occupies cycles t+2 .. t+N_CARDS.
  - DONE is cycle t+N_CARDS+1: `done_o` is high there and `valid_o` rises at its end.
  - For N_CARDS=16: `busy_o` is high for 17 cycles and `done_o` appears 17 cycles after the start edge.
- The next start can be accepted one cycle after DONE.
- Reset asserted mid-operation restores all reset values immediately (asynchronous). No partial layout survives.

## Structure
- `lab3_params` package gains:
  - `typedef enum logic [1:0] {SH_IDLE, SH_INIT, SH_SWAP, SH_DONE} shuffle_state_e`.
  - Constant `LFSR16_TAPS = 16'hB400`.
- One sub-module is natural: `lfsr16` (clk, rst, seed parameter, 16-bit state output, free-running).
- The swap index multiplier stays inline; it is a 4×5 product taking the top bits.

## Test plan
- Reset check: release reset with `LFSR_SEED`=16'hACE1 → `layout_o` = 0,0,1,1,…,7,7; `busy_o`=`done_o`=`valid_o`=0; `rnd4_o`=4'h1.
- Latency: pulse `start_i` at edge t → `busy_o` high t+1..t+17; `done_o` high only in cycle t+17; `valid_o`=1 from t+18.
- Pair invariant: 200 shuffles with random start gaps → each symbol 0..7 appears exactly twice every time. Also compare against a reference model of the same LFSR and j formula, which must match bit-exactly.
- Ignored start: `start_i` held high during cycles t+3..t+10 → single `done_o` at t+17; no second shuffle begins until after returning to IDLE.
- Reset mid-shuffle: assert `rst` at cycle t+8 → outputs return to reset values in the same cycle; after release, a fresh start completes normally in 17 cycles.
- Entropy and seed: two shuffles started 1 cycle apart from identical reset produce different layouts. With `LFSR_SEED`=0 → `rnd4_o`=4'h1 after reset and shuffles complete with pairs intact.
